// File: rtl/tdc_delay_line_channel_if.sv
// Timestamp readout interface of tdc_delay_line_channel.
// The channel is the master: it presents the FIFO head and the drop counter.
// The readout logic is the slave: it returns ts_ready.
interface tdc_delay_line_channel_if #(
   parameter int COARSE_W = 24,
   parameter int FW       = 7
);
   logic                ts_valid;
   logic                ts_ready;
   logic [COARSE_W-1:0] ts_coarse;
   logic [FW-1:0]       ts_fine;
   logic [7:0]          drop_count;

   modport master (
      output ts_valid,
      output ts_coarse,
      output ts_fine,
      output drop_count,
      input  ts_ready
   );

   modport slave (
      input  ts_valid,
      input  ts_coarse,
      input  ts_fine,
      input  drop_count,
      output ts_ready
   );
endinterface

// File: rtl/tdc_delay_line_channel.sv
// Single-channel tapped-delay-line TDC.
//
// Data path:
//   hit -> carry-in cell -> TAPS carry cells -> tap FFs (S1) -> S2
//   -> [optional majority bubble filter] -> edge detect and encode
//   -> timestamp FIFO.
//
// A free-running coarse counter is delayed through the same number of
// stages as the thermometer code. Each timestamp therefore carries the
// counter value of the cycle in which the edge entered tap 0.
//
// Build option: defining TDC_BUBBLE_FILTER_EN inserts one registered
// majority-of-three stage between S2 and the detector. This adds one cycle
// of latency and one cycle of coarse delay.
//
// The three small wrapper modules below are the carry-in, carry-cell and
// capture-FF primitives of the delay line. For a Cyclone V build they are
// the points where the vendor LCELL carry/FF cells are substituted. The
// keep attributes stop synthesis from collapsing the chain into a single
// wire.

// Carry-in cell: launches the hit onto the chain.
module tdc_carry_in (
   input  logic din,
   output logic cout
);
   assign cout = din;
endmodule

// One full-adder carry cell. With a=0, b=1 it propagates cin to cout and
// presents ~cin on its sum output.
module tdc_carry_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Capture flop behind each tap.
module tdc_tap_ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   // Sample the tap on every clock edge; clear on reset.
   // NOTE: clocked state always uses non-blocking (<=) so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end
endmodule

module tdc_delay_line_channel #(
   parameter  int TAPS     = 64,
   parameter  int COARSE_W = 24,
   parameter  int DEPTH    = 8,
   localparam int FW       = $clog2(TAPS + 1),
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic hit,
   input  logic enable,
   tdc_delay_line_channel_if.master ts
);

   localparam logic [AW:0]       PTR_ONE = (AW + 1)'(1);
   localparam logic [COARSE_W-1:0] CNT_ONE = COARSE_W'(1);

   typedef struct packed {
      logic [COARSE_W-1:0] coarse;
      logic [FW-1:0]       fine;
   } ts_entry_t;

   // ------------------------------------------------------------------
   // Delay line and first capture stage (S1)
   // ------------------------------------------------------------------
   (* keep *) logic [TAPS:0]   carry;
   (* keep *) logic [TAPS-1:0] chain_sum;
   logic [TAPS-1:0]            line_taps;
   logic [TAPS-1:0]            s1;
   logic                       chain_unused;

   tdc_carry_in u_carry_in (
      .din  (hit),
      .cout (carry[0])
   );

   for (genvar i = 0; i < TAPS; i++) begin : g_chain
      tdc_carry_cell u_cell (
         .a    (1'b0),
         .b    (1'b1),
         .cin  (carry[i]),
         .sum  (chain_sum[i]),
         .cout (carry[i+1])
      );

      tdc_tap_ff u_ff (
         .clk (clk),
         .rst (rst),
         .d   (line_taps[i]),
         .q   (s1[i])
      );
   end

   // The sum of a propagating cell is the inverse of its carry-in. Inverting
   // restores a thermometer code: a 1 means the hit has passed that tap.
   assign line_taps = ~chain_sum;

   // The terminal carry of the last cell has no consumer.
   assign chain_unused = carry[TAPS];

   // ------------------------------------------------------------------
   // Metastability stage (S2) and coarse time base
   // ------------------------------------------------------------------
   logic [TAPS-1:0]     s2;
   logic [COARSE_W-1:0] coarse_cnt;
   logic [COARSE_W-1:0] coarse_s1;
   logic [COARSE_W-1:0] coarse_s2;

   // Re-sample S1 and advance the free-running counter. The coarse copies
   // travel in lock-step with S1/S2 so each one names its capture cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2         <= '0;
         coarse_cnt <= '0;
         coarse_s1  <= '0;
         coarse_s2  <= '0;
      end else begin
         s2         <= s1;
         coarse_cnt <= coarse_cnt + CNT_ONE;
         coarse_s1  <= coarse_cnt;
         coarse_s2  <= coarse_s1;
      end
   end

   // ------------------------------------------------------------------
   // Optional bubble filter
   // ------------------------------------------------------------------
   logic [TAPS-1:0]     det_vec;
   logic [COARSE_W-1:0] det_coarse;

`ifdef TDC_BUBBLE_FILTER_EN
   logic [TAPS+1:0]     s2_pad;
   logic [TAPS-1:0]     s3;
   logic [COARSE_W-1:0] coarse_s3;

   // Pad the ends: a virtual tap below tap 0 reads 1 and a virtual tap
   // above the top reads 0, so the ends of the code are not eroded.
   assign s2_pad = {1'b0, s2, 1'b1};

   // Majority of each tap and its two neighbours removes single-tap bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3        <= '0;
         coarse_s3 <= '0;
      end else begin
         for (int i = 0; i < TAPS; i++) begin
            s3[i] <= (s2_pad[i]   & s2_pad[i+1]) |
                     (s2_pad[i]   & s2_pad[i+2]) |
                     (s2_pad[i+1] & s2_pad[i+2]);
         end
         coarse_s3 <= coarse_s2;
      end
   end

   assign det_vec    = s3;
   assign det_coarse = coarse_s3;
`else
   assign det_vec    = s2;
   assign det_coarse = coarse_s2;
`endif

   // ------------------------------------------------------------------
   // Edge detect and fine encode
   // ------------------------------------------------------------------
   logic          det_prev;
   logic          evt;
   logic [FW-1:0] fine_code;

   // Remember tap 0 of the previous cycle. A new event needs tap 0 to fall
   // back to 0 first (rearm).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) det_prev <= 1'b0;
      else     det_prev <= det_vec[0];
   end

   // Rising edge on tap 0. enable only gates at this point: samples already
   // past this stage are still pushed.
   assign evt = det_vec[0] & ~det_prev & enable;

   // Fine code = number of taps traversed = index+1 of the highest set tap.
   // NOTE: the default assignment before the loop keeps this purely
   // combinational; without it a path that sets nothing would infer a latch.
   always_comb begin
      fine_code = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (det_vec[i]) fine_code = FW'(i + 1);
      end
   end

   // ------------------------------------------------------------------
   // Timestamp FIFO and drop counter
   // ------------------------------------------------------------------
   ts_entry_t  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  drop_cnt;
   logic        fifo_empty;
   logic        fifo_full;
   logic        do_pop;
   logic        do_push;
   logic        do_drop;
   ts_entry_t   head;

   // The pointers carry one extra wrap bit, so full and empty can be told
   // apart without a separate occupancy counter.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop in the same cycle frees the slot that a push into a full FIFO
   // needs.
   assign do_pop  = ~fifo_empty & ts.ts_ready;
   assign do_push = evt & (~fifo_full | do_pop);
   assign do_drop = evt & fifo_full & ~do_pop;

   // Storage for queued timestamps.
   // NOTE: the array is cleared on reset on purpose. It is only DEPTH
   // entries, and clearing it makes the head outputs read 0 after reset
   // instead of X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= '{coarse: det_coarse, fine: fine_code};
      end
   end

   // Advance the read and write pointers on pop and push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Count events lost to a full FIFO; saturate at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            drop_cnt <= '0;
      else if (do_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
   end

   assign head          = mem[rd_ptr[AW-1:0]];
   assign ts.ts_valid   = ~fifo_empty;
   assign ts.ts_coarse  = head.coarse;
   assign ts.ts_fine    = head.fine;
   assign ts.drop_count = drop_cnt;

endmodule

// File: tb/tb_tdc_delay_line_channel.sv
// Bench for tdc_delay_line_channel.
//
// The thermometer code seen by the tap flops comes from a behavioural
// chain model. The model drives the line_taps net to the pattern that a
// real delay line would present at the first sampling edge after a hit.
// The last test releases the model and uses the real carry chain.
//
// Scoreboard: each hit pushes its expected timestamp, with the edge at
// which it is due to reach the FIFO, into a pending queue. A reference
// FIFO applies the push/pop/drop rules at every edge. The monitor compares
// the DUT head on every handshake, and ts_valid/drop_count every cycle.
module tb_tdc_delay_line_channel;

   localparam int TAPS  = 64;
   localparam int CW    = 4;
   localparam int DEPTH = 8;
   localparam int FW    = $clog2(TAPS + 1);
`ifdef TDC_BUBBLE_FILTER_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      int          due;
      logic [CW-1:0] coarse;
      int          fine;
   } pend_t;

   typedef struct {
      logic [CW-1:0] coarse;
      int          fine;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hit = 1'b0;
   logic enable = 1'b0;

   tdc_delay_line_channel_if #(.COARSE_W(CW), .FW(FW)) ts_if ();

   tdc_delay_line_channel #(
      .TAPS     (TAPS),
      .COARSE_W (CW),
      .DEPTH    (DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .hit    (hit),
      .enable (enable),
      .ts     (ts_if)
   );

   always #5 clk = ~clk;

   pend_t           pending[$];
   ent_t            model_fifo[$];
   int              model_drops = 0;
   int              ecount = 0;   // clock edges since reset release
   int              ready_mode = 0; // 0 low, 1 random, 2 high, 3 only at ready_edge
   int              ready_edge = -1;
   int              passed = 0;
   int              total = 0;
   logic [TAPS-1:0] chain_model;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Tap i of a code, with a virtual 1 below tap 0 and a virtual 0 above
   // the top tap.
   function automatic int tap(input logic [TAPS-1:0] p, input int i);
      if (i < 0) return 1;
      if (i >= TAPS) return 0;
      return int'(p[i]);
   endfunction

   // Expected fine code: taps traversed, i.e. the position of the highest
   // 1 after the optional majority clean-up.
   function automatic int ref_fine(input logic [TAPS-1:0] p);
      int result;
      result = 0;
      for (int i = 0; i < TAPS; i++) begin
         int v;
`ifdef TDC_BUBBLE_FILTER_EN
         v = ((tap(p, i - 1) + tap(p, i) + tap(p, i + 1)) >= 2) ? 1 : 0;
`else
         v = tap(p, i);
`endif
         if (v == 1) result = i + 1;
      end
      return result;
   endfunction

   function automatic logic [TAPS-1:0] thermo(input int k);
      logic [TAPS-1:0] p;
      p = '0;
      for (int i = 0; i < k; i++) p[i] = 1'b1;
      return p;
   endfunction

   task automatic set_line(input logic [TAPS-1:0] v);
      chain_model = v;
      force dut.line_taps = chain_model;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_hit(input logic [TAPS-1:0] pat);
      pend_t p;
      p.due    = ecount + LAT;
      p.coarse = CW'(ecount);
      p.fine   = ref_fine(pat);
      pending.push_back(p);
   endtask

   // A hit through the modelled line. The first sample sees the pattern;
   // from then on the edge has run through the whole line. The hit is held
   // high for 2 cycles and then low for 2 cycles.
   task automatic fire_hit(input logic [TAPS-1:0] pat, input logic en);
      enable = en;
      hit    = 1'b1;
      set_line(pat);
      expect_hit(pat);
      step();
      set_line('1);
      step();
      hit = 1'b0;
      set_line('0);
      step();
      step();
   endtask

   // Reference FIFO: applied at every edge, from the spec's push/pop rules.
   always @(posedge clk) begin : model_p
      bit    pop;
      pend_t p;
      ent_t  e;
      if (!rst) begin
         pop = (model_fifo.size() > 0) && (ts_if.ts_ready === 1'b1);
         ecount++;
         if (pop) void'(model_fifo.pop_front());
         while (pending.size() > 0 && pending[0].due == ecount) begin
            p = pending.pop_front();
            if (enable) begin
               if (model_fifo.size() < DEPTH) begin
                  e.coarse = p.coarse;
                  e.fine   = p.fine;
                  model_fifo.push_back(e);
               end else if (model_drops < 255) begin
                  model_drops++;
               end
            end
         end
      end
   end

   // Monitor: drives ready for the next edge and compares the head on each
   // handshake.
   always @(negedge clk) begin : monitor_p
      case (ready_mode)
         0:       ts_if.ts_ready = 1'b0;
         1:       ts_if.ts_ready = 1'($urandom_range(0, 1));
         2:       ts_if.ts_ready = 1'b1;
         default: ts_if.ts_ready = (ecount + 1 == ready_edge);
      endcase
      if (!rst) begin
         check("valid", ts_if.ts_valid, model_fifo.size() > 0);
         check("drop_count", ts_if.drop_count, model_drops);
         if (ts_if.ts_valid && ts_if.ts_ready && model_fifo.size() > 0) begin
            check("ts_coarse", ts_if.ts_coarse, model_fifo[0].coarse);
            check("ts_fine", ts_if.ts_fine, model_fifo[0].fine);
         end
      end
   end

   initial begin : stim_p
      logic [TAPS-1:0] pat;
      int              k;
      ts_if.ts_ready = 1'b0;
      set_line('0);
      repeat (3) step();

      // Reset state.
      check("rst_valid", ts_if.ts_valid, 0);
      check("rst_coarse", ts_if.ts_coarse, 0);
      check("rst_fine", ts_if.ts_fine, 0);
      check("rst_drop", ts_if.drop_count, 0);
      rst = 1'b0;
      ecount = 0;
      ready_mode = 2;

      // Single hit: the edge reaches tap 20 when sampled at edge 100.
      while (ecount != 99) step();
      fire_hit(thermo(21), 1'b1);

      // Saturation: all taps set.
      fire_hit('1, 1'b1);

      // Bubble: taps 0..30 set with tap 12 cleared.
      pat = thermo(31);
      pat[12] = 1'b0;
      fire_hit(pat, 1'b1);

      // enable low at detect: no entry.
      fire_hit(thermo(40), 1'b0);

      // Coarse wrap: hits at counter 15 and then at counter 0.
      while ((ecount % 16) != 15) step();
      fire_hit(thermo(9), 1'b1);
      while ((ecount % 16) != 0) step();
      fire_hit(thermo(10), 1'b1);

      // Backpressure: 10 hits into an 8-deep FIFO with no reads.
      repeat (3) step();
      ready_mode = 0;
      step();
      for (int i = 0; i < 10; i++) fire_hit(thermo(i + 5), 1'b1);
      check("bp_drop", ts_if.drop_count, 2);
      check("bp_valid", ts_if.ts_valid, 1);

      // Hit and pop on the same edge while full: accepted, no drop.
      ready_edge = ecount + LAT;
      ready_mode = 3;
      fire_hit(thermo(50), 1'b1);
      check("full_pop_drop", ts_if.drop_count, 2);
      ready_mode = 2;
      repeat (12) step();

      // Reset mid-stream with 3 queued entries.
      ready_mode = 0;
      step();
      for (int i = 0; i < 3; i++) fire_hit(thermo(i + 30), 1'b1);
      rst = 1'b1;
      pending.delete();
      model_fifo.delete();
      model_drops = 0;
      step();
      check("mid_rst_valid", ts_if.ts_valid, 0);
      check("mid_rst_drop", ts_if.drop_count, 0);
      check("mid_rst_coarse", ts_if.ts_coarse, 0);
      check("mid_rst_fine", ts_if.ts_fine, 0);
      rst = 1'b0;
      ecount = 0;
      ready_mode = 2;
      fire_hit(thermo(17), 1'b1);  // counter restarts: coarse expected 0

      // Random traffic: random code lengths, occasional bubbles, random
      // enable, random ready, random gaps.
      ready_mode = 1;
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(1, TAPS);
         pat = thermo(k);
         if (k >= 5 && $urandom_range(0, 3) == 0) pat[$urandom_range(2, k - 3)] = 1'b0;
         fire_hit(pat, 1'($urandom_range(0, 6) != 0));
         repeat ($urandom_range(0, 3)) step();
      end

      // Drain, then one hit through the real carry chain: every tap is
      // already set at the first sample.
      ready_mode = 2;
      for (int i = 0; i < 40 && model_fifo.size() > 0; i++) step();
      release dut.line_taps;
      enable = 1'b1;
      hit = 1'b1;
      expect_hit('1);
      step();
      step();
      hit = 1'b0;
      step();
      step();

      // Bounded final drain.
      for (int i = 0; i < 40 && (model_fifo.size() > 0 || pending.size() > 0); i++) step();
      check("end_pending", pending.size() + model_fifo.size(), 0);
      check("end_valid", ts_if.ts_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
